// File: rtl/scrn_pkg.sv
// scrn_pkg: display timing constants, pixel type and line-fetch state encoding
package scrn_pkg;
   localparam int H_ACT  = 640;
   localparam int V_ACT  = 480;
   localparam int H_FP   = 16;
   localparam int H_SYNC = 96;
   localparam int H_BP   = 48;
   localparam int V_FP   = 10;
   localparam int V_SYNC = 2;
   localparam int V_BP   = 33;
   typedef logic [11:0] pixel_t;
   typedef enum logic [1:0] {IDLE, REQ, DRAIN} fetch_st_e;
endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: framebuffer read bus, in-order responses without backpressure
interface fb_scanout_if
   import scrn_pkg::*;
#(
   parameter int ADDR_W   = 15,
   parameter int PIX_BITS = $bits(pixel_t)
);
   logic                mem_req_valid;
   logic                mem_req_ready;
   logic [ADDR_W-1:0]   mem_req_addr;
   logic                mem_rsp_valid;
   logic [PIX_BITS-1:0] mem_rsp_data;
   modport master (output mem_req_valid, mem_req_addr, input mem_req_ready, mem_rsp_valid, mem_rsp_data);
   modport slave  (input mem_req_valid, mem_req_addr, output mem_req_ready, mem_rsp_valid, mem_rsp_data);
endinterface

// File: rtl/line_buf_dp.sv
// line_buf_dp: ping-pong line buffer, one write port and one registered read port.
// Address is {bank, col}, so each bank occupies a power-of-two slot.
module line_buf_dp #(
   parameter int FB_W     = 160,
   parameter int PIX_BITS = 12,
   parameter int CW       = $clog2(FB_W)
) (
   input  logic                clk_i,
   input  logic                we_i,
   input  logic [CW:0]         wa_i,
   input  logic [PIX_BITS-1:0] wd_i,
   input  logic [CW:0]         ra_i,
   output logic [PIX_BITS-1:0] rd_o
);
   logic [PIX_BITS-1:0] mem_q [2**(CW+1)];
   logic [PIX_BITS-1:0] rd_q;
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[wa_i] <= wd_i;
      rd_q <= mem_q[ra_i];
   end
   assign rd_o = rd_q;
endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: scales a low-res framebuffer onto the display, fetching each row
// into the idle half of a ping-pong line buffer while the other half is shown.
module fb_scanout
   import scrn_pkg::*;
#(
   parameter int WIDTH       = 10,
   parameter int H_ACT_PIX   = H_ACT,
   parameter int V_ACT_LINES = V_ACT,
   parameter int SCALE       = 4,
   parameter int FB_W        = 160,
   parameter int FB_H        = 120,
   parameter int PIX_BITS    = 12,
   parameter int ADDR_W      = 15
) (
   input  logic                clk_pix,
   input  logic                rst_pix_n,
   input  logic [WIDTH-1:0]    sx,
   input  logic [WIDTH-1:0]    sy,
   input  logic                hsync_in,
   input  logic                vsync_in,
   input  logic                de_in,
   fb_scanout_if.master        mem,
   output logic [PIX_BITS-1:0] pix_out,
   output logic                hsync_out,
   output logic                vsync_out,
   output logic                de_out,
   output logic                underrun
);
   localparam int SH = $clog2(SCALE);
   localparam int CW = $clog2(FB_W);
   localparam int NW = $clog2(FB_W + 1);
   fetch_st_e           st_q, st_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                bank_q, bank_d;
   logic [NW-1:0]       req_cnt_q, req_cnt_d, rsp_cnt_q, rsp_cnt_d;
   logic [1:0]          hs_q, vs_q, de_q;
   logic [CW:0]         rd_addr_q;
   logic                underrun_q;
   logic [PIX_BITS-1:0] rd_data;
   logic [WIDTH-1:0]    row;
   logic                trig_top, trig_next, trig, req_acc, rsp_acc, last_req;

   assign row       = sy >> SH;
   assign trig_top  = sx == '0 && sy == WIDTH'(V_ACT_LINES);
   assign trig_next = sx == '0 && sy < WIDTH'(V_ACT_LINES) && (sy & WIDTH'(SCALE - 1)) == '0
                      && row < WIDTH'(FB_H - 1);
   assign trig      = trig_top || trig_next;
   assign last_req  = req_acc && req_cnt_q == NW'(FB_W - 1);

   always_ff @(posedge clk_pix or negedge rst_pix_n)
      if (!rst_pix_n) st_q <= IDLE;
      else st_q <= st_d;

   always_comb
      st_d = (st_q == IDLE && trig) ? REQ :
             (st_q == REQ && last_req) ? DRAIN :
             (st_q == DRAIN && rsp_cnt_q == NW'(FB_W)) ? IDLE : st_q;

   always_comb begin
      mem.mem_req_valid = st_q == REQ;
      mem.mem_req_addr  = base_q + ADDR_W'(req_cnt_q);
      req_acc           = mem.mem_req_valid && mem.mem_req_ready;
      rsp_acc           = mem.mem_rsp_valid && st_q != IDLE;
   end

   always_comb begin
      base_d    = base_q;
      bank_d    = bank_q;
      req_cnt_d = req_cnt_q + NW'(req_acc);
      rsp_cnt_d = rsp_cnt_q + NW'(rsp_acc);
      if (st_q == IDLE && trig) begin
         base_d    = trig_top ? '0 : ADDR_W'((32'(row) + 1) * FB_W);
         bank_d    = trig_top ? 1'b0 : ~row[0];
         req_cnt_d = '0;
         rsp_cnt_d = '0;
      end
   end

   // Blanking columns clamp to 0 so the read address never leaves the written range.
   always_ff @(posedge clk_pix or negedge rst_pix_n)
      if (!rst_pix_n) begin
         base_q     <= '0;
         bank_q     <= 1'b0;
         req_cnt_q  <= '0;
         rsp_cnt_q  <= '0;
         hs_q       <= '1;
         vs_q       <= '1;
         de_q       <= '0;
         rd_addr_q  <= '0;
         underrun_q <= 1'b0;
      end else begin
         base_q     <= base_d;
         bank_q     <= bank_d;
         req_cnt_q  <= req_cnt_d;
         rsp_cnt_q  <= rsp_cnt_d;
         hs_q       <= {hs_q[0], hsync_in};
         vs_q       <= {vs_q[0], vsync_in};
         de_q       <= {de_q[0], de_in};
         rd_addr_q  <= {row[0], sx < WIDTH'(H_ACT_PIX) ? sx[SH +: CW] : CW'(0)};
         underrun_q <= trig && st_q != IDLE;
      end

   line_buf_dp #(.FB_W(FB_W), .PIX_BITS(PIX_BITS)) u_lb (
      .clk_i (clk_pix),
      .we_i  (rsp_acc),
      .wa_i  ({bank_q, rsp_cnt_q[CW-1:0]}),
      .wd_i  (mem.mem_rsp_data),
      .ra_i  (rd_addr_q),
      .rd_o  (rd_data)
   );

   assign pix_out   = de_q[1] ? rd_data : '0;
   assign hsync_out = hs_q[1];
   assign vsync_out = vs_q[1];
   assign de_out    = de_q[1];
   assign underrun  = underrun_q;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed frame fragments against a 3-cycle-latency memory
// returning addr[11:0]; sync/de/pixel outputs are checked two cycles behind.
module tb_fb_scanout;
   import scrn_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [9:0] sx = '0, sy = '0;
   logic hs_in = 1'b1, vs_in = 1'b1, de_in = 1'b0;
   logic [11:0] pix;
   logic hs_out, vs_out, de_out, urun;
   int total = 0, bad = 0;

   fb_scanout_if #(.ADDR_W(15), .PIX_BITS(12)) mem_if ();

   fb_scanout dut (
      .clk_pix(clk), .rst_pix_n(rst_n), .sx(sx), .sy(sy),
      .hsync_in(hs_in), .vsync_in(vs_in), .de_in(de_in), .mem(mem_if),
      .pix_out(pix), .hsync_out(hs_out), .vsync_out(vs_out), .de_out(de_out), .underrun(urun)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [9:0] x; logic [9:0] y; logic hs; logic vs; logic de; logic chk;} drv_t;
   drv_t d1, d2;
   bit chk_pix = 0;
   int mode = 1;
   int acc_cnt = 0, exp_base = 0, ur_cnt = 0;
   logic [9:0] ur_x = '0, ur_y = '0;
   logic pv_valid = 0, pv_ready = 0, p0v = 0, p1v = 0;
   logic [14:0] pv_addr = '0;
   logic [11:0] p0d = '0, p1d = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, want);
      end
   endtask

   task automatic mdl_clr();
      pv_valid = 0; pv_ready = 0; p0v = 0; p1v = 0;
      mem_if.mem_rsp_valid = 1'b0;
      mem_if.mem_req_ready = 1'b0;
   endtask

   // One pixel clock: memory model, delayed-output checks, then drive the next position.
   task automatic step(input int x, input int y);
      logic acc;
      logic [11:0] e;
      @(negedge clk);
      acc = pv_valid && pv_ready;
      if (pv_valid && !pv_ready)
         chk("req_hold", {mem_if.mem_req_valid, mem_if.mem_req_addr}, {1'b1, pv_addr});
      if (acc) begin
         chk("req_addr", pv_addr, exp_base + acc_cnt);
         acc_cnt++;
      end
      mem_if.mem_rsp_valid = p1v;
      mem_if.mem_rsp_data  = p1d;
      p1v = p0v; p1d = p0d; p0v = acc; p0d = pv_addr[11:0];
      mem_if.mem_req_ready = mode == 1 ? 1'b1 : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
      pv_valid = mem_if.mem_req_valid; pv_ready = mem_if.mem_req_ready; pv_addr = mem_if.mem_req_addr;
      chk("hsync", hs_out, d2.hs);
      chk("vsync", vs_out, d2.vs);
      chk("de", de_out, d2.de);
      if (!d2.de) chk("pix_blank", pix, 0);
      else if (d2.chk) begin
         e = 12'((d2.y >> 2) * 160 + (d2.x >> 2));
         chk("pix", pix, e);
      end
      if (urun) begin ur_cnt++; ur_x = d1.x; ur_y = d1.y; end
      d2 = d1;
      sx = 10'(x); sy = 10'(y);
      hs_in = !(x >= H_ACT + H_FP && x < H_ACT + H_FP + H_SYNC);
      vs_in = !(y >= V_ACT + V_FP && y < V_ACT + V_FP + V_SYNC);
      de_in = x < H_ACT && y < V_ACT;
      d1 = '{sx, sy, hs_in, vs_in, de_in, chk_pix};
   endtask

   task automatic run(input int y, input int x0 = 0, input int x1 = 799);
      for (int x = x0; x <= x1; x++) step(x, y);
   endtask

   task automatic park_inputs();
      sx = 10'd799; sy = 10'd524; hs_in = 1'b1; vs_in = 1'b1; de_in = 1'b0;
      d1 = '{10'd799, 10'd524, 1'b1, 1'b1, 1'b0, 1'b0};
      d2 = d1;
   endtask

   initial begin
      int x;
      mdl_clr();
      mem_if.mem_rsp_data = '0;
      park_inputs();
      // Reset held while the position runs, including an sx==0 trigger point.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("rst_hsync", hs_out, 1);
         chk("rst_vsync", vs_out, 1);
         chk("rst_de", de_out, 0);
         chk("rst_pix", pix, 0);
         chk("rst_valid", mem_if.mem_req_valid, 0);
         chk("rst_underrun", urun, 0);
         sx = 10'(i); sy = '0; de_in = 1'b1; hs_in = i[0]; vs_in = i[1];
      end
      @(negedge clk);
      park_inputs();
      rst_n = 1'b1;

      mode = 1; exp_base = 160; acc_cnt = 0;
      run(0);
      chk("fetch_row1_cnt", acc_cnt, 160);
      run(1); run(2); run(3);
      chk_pix = 1; exp_base = 320; acc_cnt = 0;
      run(4, 0, 10);
      chk("pix_sy4_sx8", pix, 12'h0A2);
      run(4, 11, 799);
      chk("fetch_row2_cnt", acc_cnt, 160);

      mode = 2; exp_base = 480; acc_cnt = 0;
      run(8);
      chk("fetch_row3_rand_cnt", acc_cnt, 160);
      mode = 1; exp_base = 640; acc_cnt = 0;
      run(12);
      chk("fetch_row4_cnt", acc_cnt, 160);

      chk_pix = 0; acc_cnt = 0;
      run(476);
      chk("no_fetch_row119", acc_cnt, 0);
      exp_base = 0;
      run(480);
      chk("fetch_row0_cnt", acc_cnt, 160);
      chk_pix = 1; exp_base = 160; acc_cnt = 0;
      run(0);
      chk("frame2_row1_cnt", acc_cnt, 160);
      chk("no_underrun_yet", ur_cnt, 0);

      // Memory stalls from the sy=0 trigger; sy=4 trigger must be dropped.
      chk_pix = 0; mode = 0; exp_base = 160; acc_cnt = 0;
      run(0); run(1); run(2); run(3);
      chk("ur_before", ur_cnt, 0);
      run(4);
      chk("ur_cnt", ur_cnt, 1);
      chk("ur_pos", {ur_y, ur_x}, {10'd4, 10'd0});
      run(5);
      run(6, 0, 199);
      chk("stall_no_acc", acc_cnt, 0);
      chk("stall_valid", mem_if.mem_req_valid, 1);
      chk("stall_addr", mem_if.mem_req_addr, 160);
      mode = 1;
      run(6, 200, 799);
      run(7);
      chk("ur_total", ur_cnt, 1);
      chk("one_fetch", acc_cnt, 160);

      // Reset in the middle of a fetch, then a clean restart from the row base.
      exp_base = 160; acc_cnt = 0; x = 0;
      while (acc_cnt < 37 && x < 800) begin
         step(x, 0);
         x++;
      end
      chk("reach_37", acc_cnt, 37);
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", mem_if.mem_req_valid, 0);
      chk("rst_async_de", de_out, 0);
      park_inputs();
      mdl_clr();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      acc_cnt = 0;
      run(0);
      chk("restart_cnt", acc_cnt, 160);
      chk_pix = 1; exp_base = 320; acc_cnt = 0;
      run(4);
      chk("after_restart_row2_cnt", acc_cnt, 160);
      chk("ur_final", ur_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
